// File: rtl/glitch_cmd_sender_if.sv
`default_nettype none
// ============================================================================
// Module      : glitch_cmd_sender_if
// Description : Command, UART TX/RX and status bundle for glitch_cmd_sender.
//               The slave modport is the sender's view; master is the host's.
// Revision    : 1.0 - initial release
// ============================================================================
interface glitch_cmd_sender_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [2:0]  cmd_op_i;
    logic [15:0] cmd_arg_i;
    logic [7:0]  tx_data_o;
    logic        tx_enable_o;
    logic        tx_busy_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        done_o;
    logic        hello_ok_o;
    logic        hello_fail_o;

    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_arg_i, tx_busy_i, rx_data_i, rx_valid_i,
        output cmd_ready_o, tx_data_o, tx_enable_o, done_o, hello_ok_o, hello_fail_o
    );

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_arg_i, tx_busy_i, rx_data_i, rx_valid_i,
        input  cmd_ready_o, tx_data_o, tx_enable_o, done_o, hello_ok_o, hello_fail_o
    );
endinterface
`default_nettype wire

// File: rtl/glitch_cmd_sender.sv
`default_nettype none
// ============================================================================
// Module      : glitch_cmd_sender
// Description : Serialises a captured opcode/argument into UART bytes, one
//               byte per idle transmitter slot. Optional "Hello\n" reply
//               checking for op 6 is compiled in by defining
//               GLITCH_CMD_SENDER_HELLO_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module glitch_cmd_sender #(
    parameter int HELLO_TIMEOUT = 1_000_000
) (
    input logic               clk,
    input logic               rst,
    glitch_cmd_sender_if.slave bus
);

    localparam logic [2:0] c_ST_IDLE       = 3'd0;
    localparam logic [2:0] c_ST_OPCODE     = 3'd1;
    localparam logic [2:0] c_ST_ARG_HI     = 3'd2;
    localparam logic [2:0] c_ST_ARG_LO     = 3'd3;
`ifdef GLITCH_CMD_SENDER_HELLO_CHECK_EN
    localparam logic [2:0] c_ST_HELLO_WAIT = 3'd4;
    localparam int         c_CNT_W         = (HELLO_TIMEOUT > 1) ? $clog2(HELLO_TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(HELLO_TIMEOUT - 1);
`endif

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic [2:0]  r_op;
    logic [15:0] r_arg;
    logic [7:0]  r_tx_data;
    logic        r_tx_enable;
    logic        r_done;
    logic        w_can_issue;
    logic        w_accept;
    logic        w_issue;
    logic [7:0]  w_byte;
    logic        w_done;

    // Opcode character sent first for every op except the raw byte (op 7)
    function automatic logic [7:0] f_op_char(input logic [2:0] op);
        case (op)
            3'd0:    return 8'h64;
            3'd1:    return 8'h77;
            3'd2:    return 8'h6E;
            3'd3:    return 8'h73;
            3'd4:    return 8'h72;
            3'd5:    return 8'h74;
            3'd6:    return 8'h68;
            default: return 8'h00;
        endcase
    endfunction

`ifdef GLITCH_CMD_SENDER_HELLO_CHECK_EN
    logic [2:0]         r_hello_idx;
    logic [c_CNT_W-1:0] r_hello_cnt;
    logic               r_hello_ok;
    logic               r_hello_fail;
    logic               w_hello_ok;
    logic               w_hello_fail;
    logic               w_enter_hello;
    logic               w_rx_match;

    // Expected reply "Hello\n", one character per index
    function automatic logic [7:0] f_hello_char(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h48;
            3'd1:    return 8'h65;
            3'd2:    return 8'h6C;
            3'd3:    return 8'h6C;
            3'd4:    return 8'h6F;
            3'd5:    return 8'h0A;
            default: return 8'h00;
        endcase
    endfunction

    assign w_rx_match = (bus.rx_data_i == f_hello_char(r_hello_idx));
`endif

    // A byte may only start when the transmitter is idle and no strobe is in flight
    assign w_can_issue = !bus.tx_busy_i && !r_tx_enable;
    assign w_accept    = (r_state == c_ST_IDLE) && bus.cmd_valid_i;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state selection
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.cmd_valid_i) w_state_next = c_ST_OPCODE;
            end
            c_ST_OPCODE: begin
                if (w_can_issue) begin
                    case (r_op)
                        3'd0, 3'd3, 3'd4: w_state_next = c_ST_ARG_HI;
                        3'd1, 3'd2:       w_state_next = c_ST_ARG_LO;
`ifdef GLITCH_CMD_SENDER_HELLO_CHECK_EN
                        3'd6:             w_state_next = c_ST_HELLO_WAIT;
`endif
                        default:          w_state_next = c_ST_IDLE;
                    endcase
                end
            end
            c_ST_ARG_HI: begin
                if (w_can_issue) w_state_next = c_ST_ARG_LO;
            end
            c_ST_ARG_LO: begin
                if (w_can_issue) w_state_next = c_ST_IDLE;
            end
`ifdef GLITCH_CMD_SENDER_HELLO_CHECK_EN
            c_ST_HELLO_WAIT: begin
                if (w_hello_ok || w_hello_fail) w_state_next = c_ST_IDLE;
            end
`endif
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // Per-state byte issue, completion and hello outcome decisions
    always_comb begin
        w_issue = 1'b0;
        w_byte  = 8'h00;
        w_done  = 1'b0;
`ifdef GLITCH_CMD_SENDER_HELLO_CHECK_EN
        w_hello_ok    = 1'b0;
        w_hello_fail  = 1'b0;
        w_enter_hello = 1'b0;
`endif
        case (r_state)
            c_ST_OPCODE: begin
                if (w_can_issue) begin
                    w_issue = 1'b1;
                    w_byte  = (r_op == 3'd7) ? r_arg[7:0] : f_op_char(r_op);
`ifdef GLITCH_CMD_SENDER_HELLO_CHECK_EN
                    w_done        = (r_op == 3'd5) || (r_op == 3'd7);
                    w_enter_hello = (r_op == 3'd6);
`else
                    w_done = (r_op == 3'd5) || (r_op == 3'd6) || (r_op == 3'd7);
`endif
                end
            end
            c_ST_ARG_HI: begin
                if (w_can_issue) begin
                    w_issue = 1'b1;
                    w_byte  = r_arg[15:8];
                end
            end
            c_ST_ARG_LO: begin
                if (w_can_issue) begin
                    w_issue = 1'b1;
                    w_byte  = r_arg[7:0];
                    w_done  = 1'b1;
                end
            end
`ifdef GLITCH_CMD_SENDER_HELLO_CHECK_EN
            c_ST_HELLO_WAIT: begin
                // A received byte takes priority over a coincident timeout
                if (bus.rx_valid_i) begin
                    if (!w_rx_match) begin
                        w_hello_fail = 1'b1;
                    end else if (r_hello_idx == 3'd5) begin
                        w_hello_ok = 1'b1;
                    end
                end else if (r_hello_cnt == c_CNT_LAST) begin
                    w_hello_fail = 1'b1;
                end
                w_done = w_hello_ok || w_hello_fail;
            end
`endif
            default: ;
        endcase
    end

    // Command capture and registered TX/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= 3'd0;
            r_arg       <= 16'h0000;
            r_tx_data   <= 8'h00;
            r_tx_enable <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= bus.cmd_op_i;
                r_arg <= bus.cmd_arg_i;
            end
            if (w_issue) r_tx_data <= w_byte;
            r_tx_enable <= w_issue;
            r_done      <= w_done;
        end
    end

`ifdef GLITCH_CMD_SENDER_HELLO_CHECK_EN
    // Reply tracking: index of next expected character and cycles spent waiting
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hello_idx  <= 3'd0;
            r_hello_cnt  <= '0;
            r_hello_ok   <= 1'b0;
            r_hello_fail <= 1'b0;
        end else begin
            r_hello_ok   <= w_hello_ok;
            r_hello_fail <= w_hello_fail;
            if (w_enter_hello) begin
                r_hello_idx <= 3'd0;
                r_hello_cnt <= '0;
            end else if (r_state == c_ST_HELLO_WAIT) begin
                r_hello_cnt <= r_hello_cnt + c_CNT_W'(1);
                if (bus.rx_valid_i && w_rx_match) r_hello_idx <= r_hello_idx + 3'd1;
            end
        end
    end

    assign bus.hello_ok_o   = r_hello_ok;
    assign bus.hello_fail_o = r_hello_fail;
`else
    assign bus.hello_ok_o   = 1'b0;
    assign bus.hello_fail_o = 1'b0;
`endif

    assign bus.cmd_ready_o = (r_state == c_ST_IDLE);
    assign bus.tx_data_o   = r_tx_data;
    assign bus.tx_enable_o = r_tx_enable;
    assign bus.done_o      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_glitch_cmd_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_glitch_cmd_sender
// Description : Self-checking bench for glitch_cmd_sender: directed and
//               randomised commands against a byte-list reference model, with
//               a UART TX responder and an output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_glitch_cmd_sender;

    localparam int c_TIMEOUT = 40;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    glitch_cmd_sender_if bus ();

    glitch_cmd_sender #(.HELLO_TIMEOUT(c_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // UART TX responder: busy rises the cycle after a strobe, for busy_len cycles
    int   busy_len   = 2;
    int   busy_cnt   = 0;
    bit   force_busy = 1'b0;
    logic en_seen;
    always @(posedge clk) begin
        en_seen = bus.tx_enable_o;
        #1;
        if (en_seen === 1'b1) busy_cnt = busy_len;
        bus.tx_busy_i = force_busy || (busy_cnt != 0);
        if (busy_cnt != 0) busy_cnt = busy_cnt - 1;
    end

    // Output monitor sampled mid-cycle
    logic [7:0] byte_q[$];
    int   done_cnt = 0, done_at_size = 0, done_with_en = 0;
    int   ok_cnt = 0, fail_cnt = 0, viol = 0, cyc = 0;
    int   last_en_cyc = 0, last_fail_cyc = 0;
    logic prev_en = 1'b0, prev_busy = 1'b0;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.tx_enable_o === 1'b1) begin
            byte_q.push_back(bus.tx_data_o);
            last_en_cyc = cyc;
            if (prev_en === 1'b1 || prev_busy === 1'b1) viol = viol + 1;
        end
        if (bus.done_o === 1'b1) begin
            done_cnt     = done_cnt + 1;
            done_at_size = byte_q.size();
            if (bus.tx_enable_o === 1'b1) done_with_en = done_with_en + 1;
        end
        if (bus.hello_ok_o === 1'b1) ok_cnt = ok_cnt + 1;
        if (bus.hello_fail_o === 1'b1) begin
            fail_cnt      = fail_cnt + 1;
            last_fail_cyc = cyc;
        end
        prev_en   = bus.tx_enable_o;
        prev_busy = bus.tx_busy_i;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed no end of test, expected finish before 300000 ns");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reference model: the byte list a command must produce on the UART
    logic [7:0] exp_q[$];
    task automatic model(input logic [2:0] op, input logic [15:0] arg);
        exp_q.delete();
        case (op)
            3'd0: begin exp_q.push_back(8'h64); exp_q.push_back(arg[15:8]); exp_q.push_back(arg[7:0]); end
            3'd1: begin exp_q.push_back(8'h77); exp_q.push_back(arg[7:0]); end
            3'd2: begin exp_q.push_back(8'h6E); exp_q.push_back(arg[7:0]); end
            3'd3: begin exp_q.push_back(8'h73); exp_q.push_back(arg[15:8]); exp_q.push_back(arg[7:0]); end
            3'd4: begin exp_q.push_back(8'h72); exp_q.push_back(arg[15:8]); exp_q.push_back(arg[7:0]); end
            3'd5: exp_q.push_back(8'h74);
            3'd6: exp_q.push_back(8'h68);
            default: exp_q.push_back(arg[7:0]);
        endcase
    endtask

    int b_bytes, b_done, b_den, b_ok, b_fail;

    task automatic snapshot();
        b_bytes = byte_q.size();
        b_done  = done_cnt;
        b_den   = done_with_en;
        b_ok    = ok_cnt;
        b_fail  = fail_cnt;
    endtask

    task automatic start_cmd(input logic [2:0] op, input logic [15:0] arg);
        int n = 0;
        while (bus.cmd_ready_o !== 1'b1 && n < 200) begin step(); n++; end
        chk("ready_before_cmd", 32'(bus.cmd_ready_o), 32'd1);
        snapshot();
        model(op, arg);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = op;
        bus.cmd_arg_i   = arg;
        step();
        bus.cmd_valid_i = 1'b0;
        bus.cmd_op_i    = 3'($urandom);
        bus.cmd_arg_i   = 16'($urandom);
    endtask

    task automatic wait_first_byte();
        int n = 0;
        while (byte_q.size() == b_bytes && n < 200) begin step(); n++; end
        chk("first_byte_seen", 32'(byte_q.size() - b_bytes), 32'd1);
    endtask

    task automatic finish_cmd(input string tag);
        int n = 0;
        while (done_cnt == b_done && n < 500) begin step(); n++; end
        step();
        chk({tag, "_nbytes"}, 32'(byte_q.size() - b_bytes), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (b_bytes + i < byte_q.size())
                chk($sformatf("%s_byte%0d", tag, i), 32'(byte_q[b_bytes + i]), 32'(exp_q[i]));
        end
        chk({tag, "_done_cnt"}, 32'(done_cnt - b_done), 32'd1);
        chk({tag, "_done_on_last"}, 32'(done_at_size - b_bytes), 32'(exp_q.size()));
        chk({tag, "_done_with_en"}, 32'(done_with_en - b_den), 32'd1);
        chk({tag, "_no_hello"}, 32'(ok_cnt - b_ok + fail_cnt - b_fail), 32'd0);
    endtask

    task automatic send_rx(input logic [7:0] b);
        bus.rx_data_i  = b;
        bus.rx_valid_i = 1'b1;
        step();
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'($urandom);
    endtask

    logic [7:0] hello_str[6] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0A};
    logic [7:0] hexlo_str[5] = '{8'h48, 8'h65, 8'h78, 8'h6C, 8'h6F};

    initial begin
        logic [2:0]  op;
        logic [15:0] arg;
        rst             = 1'b1;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_op_i    = 3'd0;
        bus.cmd_arg_i   = 16'h0000;
        bus.rx_data_i   = 8'h00;
        bus.rx_valid_i  = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_ready", 32'(bus.cmd_ready_o), 32'd1);
        chk("rst_tx_enable", 32'(bus.tx_enable_o), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data_o), 32'd0);
        chk("rst_done", 32'(bus.done_o), 32'd0);
        chk("rst_hello_ok", 32'(bus.hello_ok_o), 32'd0);
        chk("rst_hello_fail", 32'(bus.hello_fail_o), 32'd0);
        rst = 1'b0;
        step();

        // Three-byte command with a slow transmitter
        busy_len = 10;
        start_cmd(3'd0, 16'h1234);
        finish_cmd("op0");

        // Two-byte and single-byte commands
        busy_len = 3;
        start_cmd(3'd1, 16'hABCD);
        finish_cmd("op1");
        start_cmd(3'd5, 16'h5A5A);
        finish_cmd("op5");

        // Transmitter busy at accept: nothing may start until it drops
        force_busy = 1'b1;
        step();
        start_cmd(3'd2, 16'h00C3);
        repeat (100) step();
        chk("busy_hold_no_enable", 32'(byte_q.size() - b_bytes), 32'd0);
        force_busy = 1'b0;
        step();
        step();
        chk("busy_drop_enable", 32'(bus.tx_enable_o), 32'd1);
        finish_cmd("op2_busy");

        // Reset after the first byte aborts the command
        busy_len = 5;
        start_cmd(3'd4, 16'h0102);
        wait_first_byte();
        chk("abort_first_byte", 32'(byte_q[b_bytes]), 32'h72);
        rst             = 1'b1;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = 3'd5;
        step();
        step();
        rst             = 1'b0;
        bus.cmd_valid_i = 1'b0;
        chk("abort_ready", 32'(bus.cmd_ready_o), 32'd1);
        chk("abort_tx_data", 32'(bus.tx_data_o), 32'd0);
        repeat (20) step();
        chk("abort_no_more_bytes", 32'(byte_q.size() - b_bytes), 32'd1);
        chk("abort_no_done", 32'(done_cnt - b_done), 32'd0);
        start_cmd(3'd4, 16'h0102);
        finish_cmd("op4_after_rst");

        // Randomised commands, some back-to-back with a fast transmitter
        for (int k = 0; k < 16; k++) begin
            op  = 3'($urandom_range(0, 7));
            arg = 16'($urandom);
`ifdef GLITCH_CMD_SENDER_HELLO_CHECK_EN
            if (op == 3'd6) op = 3'd5;
`endif
            busy_len = $urandom_range(1, 12);
            start_cmd(op, arg);
            finish_cmd($sformatf("rnd%0d_op%0d", k, op));
        end

        // Received bytes while idle must not produce hello pulses
        snapshot();
        for (int i = 0; i < 6; i++) send_rx(hello_str[i]);
        repeat (3) step();
        chk("idle_rx_ignored", 32'(ok_cnt - b_ok + fail_cnt - b_fail + done_cnt - b_done), 32'd0);

`ifdef GLITCH_CMD_SENDER_HELLO_CHECK_EN
        // Correct reply
        busy_len = 2;
        start_cmd(3'd6, 16'($urandom));
        wait_first_byte();
        chk("hello_h_byte", 32'(byte_q[b_bytes]), 32'h68);
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 3)) step();
            send_rx(hello_str[i]);
        end
        chk("hello_ok_pulse", 32'(bus.hello_ok_o), 32'd1);
        chk("hello_ok_done", 32'(bus.done_o), 32'd1);
        repeat (3) step();
        chk("hello_ok_cnt", 32'(ok_cnt - b_ok), 32'd1);
        chk("hello_ok_no_fail", 32'(fail_cnt - b_fail), 32'd0);
        chk("hello_ok_done_cnt", 32'(done_cnt - b_done), 32'd1);

        // Mismatching reply fails on the third character
        start_cmd(3'd6, 16'($urandom));
        wait_first_byte();
        send_rx(hexlo_str[0]);
        send_rx(hexlo_str[1]);
        send_rx(hexlo_str[2]);
        chk("hexlo_fail_pulse", 32'(bus.hello_fail_o), 32'd1);
        chk("hexlo_done", 32'(bus.done_o), 32'd1);
        send_rx(hexlo_str[3]);
        send_rx(hexlo_str[4]);
        repeat (3) step();
        chk("hexlo_fail_cnt", 32'(fail_cnt - b_fail), 32'd1);
        chk("hexlo_no_ok", 32'(ok_cnt - b_ok), 32'd0);

        // No reply: failure exactly HELLO_TIMEOUT cycles after the 'h' strobe
        start_cmd(3'd6, 16'($urandom));
        wait_first_byte();
        begin
            int n = 0;
            while (fail_cnt == b_fail && n < c_TIMEOUT + 20) begin step(); n++; end
        end
        chk("timeout_fail_cnt", 32'(fail_cnt - b_fail), 32'd1);
        chk("timeout_latency", 32'(last_fail_cyc - last_en_cyc), 32'(c_TIMEOUT));
        chk("timeout_done_cnt", 32'(done_cnt - b_done), 32'd1);
        chk("timeout_no_ok", 32'(ok_cnt - b_ok), 32'd0);
`else
        // Op 6 behaves as a plain single-byte command
        busy_len = 2;
        start_cmd(3'd6, 16'($urandom));
        finish_cmd("op6_plain");
        snapshot();
        for (int i = 0; i < 6; i++) send_rx(hello_str[i]);
        repeat (3) step();
        chk("op6_plain_no_hello", 32'(ok_cnt - b_ok + fail_cnt - b_fail), 32'd0);
`endif

        chk("issue_rule_violations", 32'(viol), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/glitch_cmd_sender.md
GLITCH_CMD_SENDER -- requirements
Module: glitch_cmd_sender

Interface
REQ-001 The block SHALL have parameter HELLO_TIMEOUT, default 1_000_000, meaning the number of clk cycles to wait for the "Hello\n" reply before failing.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL have port cmd_valid_i, input, 1 bit: command request.
REQ-005 The block SHALL have port cmd_ready_o, output, 1 bit: block is able to accept a command.
REQ-006 The block SHALL have port cmd_op_i, input, 3 bits: operation code.
REQ-007 The block SHALL have port cmd_arg_i, input, 16 bits: command argument.
REQ-008 The block SHALL have port tx_data_o, output, 8 bits: byte to the UART transmitter.
REQ-009 The block SHALL have port tx_enable_o, output, 1 bit: one-cycle start-of-byte strobe.
REQ-010 The block SHALL have port tx_busy_i, input, 1 bit: UART transmitter busy; asserts the cycle after tx_enable_o.
REQ-011 The block SHALL have ports rx_data_i, input, 8 bits, and rx_valid_i, input, 1 bit: received UART byte with its one-cycle valid.
REQ-012 The block SHALL have port done_o, output, 1 bit: one-cycle pulse when a command completes.
REQ-013 The block SHALL have ports hello_ok_o and hello_fail_o, outputs, 1 bit each: one-cycle hello result pulses.

Function
REQ-014 The opcode map SHALL be:
- 0: 'd' (0x64) + arg[15:8] + arg[7:0]
- 1: 'w' (0x77) + arg[7:0]
- 2: 'n' (0x6E) + arg[7:0]
- 3: 's' (0x73) + arg[15:8] + arg[7:0]
- 4: 'r' (0x72) + arg[15:8] + arg[7:0]
- 5: 't' (0x74) only
- 6: 'h' (0x68) only
- 7: arg[7:0] sent alone (raw/echo byte)
REQ-015 States SHALL be IDLE, OPCODE, ARG_HI, ARG_LO, HELLO_WAIT; cmd_ready_o SHALL be 1 only in IDLE.
REQ-016 On cmd_valid_i && cmd_ready_o, the block SHALL capture cmd_op_i and cmd_arg_i, then go to OPCODE next cycle; later input changes SHALL have no effect.
REQ-017 State transitions from OPCODE SHALL be:
- ops 0/3/4 go to ARG_HI, then ARG_LO.
- ops 1/2 go directly to ARG_LO.
- op 7 sends arg[7:0] in OPCODE and finishes.
- ops 5/6 finish after the opcode byte.
REQ-018 A byte SHALL be issued only in a cycle where tx_busy_i==0 and tx_enable_o==0; issuing sets tx_data_o and pulses tx_enable_o high for exactly one cycle.
REQ-019 tx_data_o SHALL hold its value until the next byte is issued.
REQ-020 Completion SHALL assert done_o in the same cycle as the last tx_enable_o pulse, and the state SHALL return to IDLE.
REQ-021 Back-to-back operation: a new command SHALL be acceptable the cycle after done_o; its first byte still waits for tx_busy_i==0.
REQ-022 Minimum spacing between tx_enable_o pulses SHALL be 2 cycles, and no byte SHALL be dropped or duplicated for any tx_busy_i duration.
REQ-023 rx_valid_i SHALL be ignored outside HELLO_WAIT.

Reset
REQ-024 On rst, the block SHALL set:
- state to IDLE
- cmd_ready_o to 1
- tx_enable_o, done_o, hello_ok_o, hello_fail_o to 0
- tx_data_o, captured op/arg, hello index and timeout counter to 0
REQ-025 rst mid-command SHALL abort at that edge, with no further tx_enable_o pulse; a cmd_valid_i coincident with rst SHALL be ignored.

Configuration
REQ-026 The block SHALL use macro GLITCH_CMD_SENDER_HELLO_CHECK_EN to compile hello-reply checking in or out.
REQ-027 With GLITCH_CMD_SENDER_HELLO_CHECK_EN defined, op 6 SHALL behave as follows:
- After the 'h' pulse, the block goes to HELLO_WAIT with index 0 and the counter cleared.
- Each rx_valid_i byte is compared to 48 65 6C 6C 6F 0A in order.
- A mismatch pulses hello_fail_o and done_o.
- Six matches pulse hello_ok_o and done_o.
- HELLO_TIMEOUT cycles without completion pulses hello_fail_o and done_o.
- Each of these outcomes returns the block to IDLE.
REQ-028 Without GLITCH_CMD_SENDER_HELLO_CHECK_EN, op 6 SHALL complete like op 5; HELLO_WAIT and the counter are absent; hello_ok_o and hello_fail_o are constant 0; rx_data_i and rx_valid_i are unused.

Verification
REQ-029 Test op=0, arg=0x1234, tx_busy_i high 10 cycles after each enable -> tx bytes 0x64, 0x12, 0x34, with done_o on the third pulse.
REQ-030 Test op=1, arg=0xABCD -> bytes 0x77, 0xCD only; op=5 -> single byte 0x74, done_o coincident with it.
REQ-031 Test tx_busy_i held high 100 cycles at command accept -> no tx_enable_o until busy drops, then an enable within 1 cycle.
REQ-032 Test rst asserted after the first byte of op=4, arg=0x0102 -> no further enables, cmd_ready_o=1 after reset, next command sent intact.
REQ-033 Test with the macro defined: op=6 with reply "Hello\n" -> hello_ok_o; reply "Hexlo" -> hello_fail_o on the 'x' byte; no reply -> hello_fail_o after HELLO_TIMEOUT cycles.
REQ-034 Test without the macro: op=6 -> byte 0x68, done_o, no hello pulses.
